// File: rtl/shifter_32bit_pipe_lo.sv
// Low-order stages (8/4/2/1) of the 32-bit log shifter.
// Two registered stages behind a valid/ready handshake.
module shifter_32bit_pipe_lo #(
  parameter bit ARITH = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        SH_DIR,
  input  logic [4:0]  SH_AMT,
  input  logic [31:0] D_IN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] D_OUT
);

  typedef struct packed {
    logic [31:0] data;
    logic        dir;
    logic [1:0]  amt;
  } s1_t;

  s1_t         s1_q;
  s1_t         s1_d;
  logic        s1_valid;
  logic [31:0] s1_sh8;
  logic [31:0] s2_sh2;
  logic [31:0] s2_d;
  logic        s2_free;
  logic        s1_adv;
  logic        accept;
  logic        unused_amt;

  // Bit 4 was consumed by the 16-position stage.
  assign unused_amt = SH_AMT[4];

  function automatic logic [31:0] stage_sh(
    input logic [31:0] d,
    input logic        dir,
    input logic        en,
    input logic [4:0]  n
  );
    logic [63:0] t;
    logic        fill;
    fill = ARITH && d[31];
    t = {{32{fill}}, d} >> n;
    if (!en)
      return d;
    else if (dir)
      return t[31:0];
    else
      return d << n;
  endfunction

  assign s2_free  = !OUT_VALID || OUT_READY;
  assign s1_adv   = s1_valid && s2_free;
  assign IN_READY = RST_N && (!s1_valid || s2_free);
  assign accept   = IN_VALID && IN_READY;

  // S1 datapath: shift by 8 then by 4.
  always_comb begin
    s1_sh8      = stage_sh(D_IN, SH_DIR, SH_AMT[3], 5'd8);
    s1_d        = '0;
    s1_d.data   = stage_sh(s1_sh8, SH_DIR, SH_AMT[2], 5'd4);
    s1_d.dir    = SH_DIR;
    s1_d.amt    = SH_AMT[1:0];
  end

  // S2 datapath: shift by 2 then by 1.
  always_comb begin
    s2_sh2 = stage_sh(s1_q.data, s1_q.dir, s1_q.amt[1], 5'd2);
    s2_d   = stage_sh(s2_sh2, s1_q.dir, s1_q.amt[0], 5'd1);
  end

  // S1 register: loads on accept, empties when it advances.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_q     <= s1_d;
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 register: holds under backpressure, drains on consume.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      D_OUT     <= '0;
      OUT_VALID <= 1'b0;
    end else if (s1_adv) begin
      D_OUT     <= s2_d;
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule
